digit_combiner_sec: RTL and testbench
=====================================

DIGIT_COMBINER_SEC -- requirements
Module: digit_combiner_sec

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL clear immediately on i_reset_n low, independent of i_clk.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_reset_n  input  1  asynchronous active-low reset.
REQ-004 i_digit  input  4  BCD digit offered for entry.
REQ-005 i_digit_valid  input  1  i_digit is offered this cycle.
REQ-006 i_clear  input  1  abort partial entry, synchronous.
REQ-007 o_ready  output  1  a digit is accepted this cycle if i_digit_valid is also high.
REQ-008 o_digit_idx  output  2  position expected next: 3=min tens, 2=min ones, 1=sec tens, 0=sec ones.
REQ-009 o_min  output  6  committed minutes, binary, 0..59.
REQ-010 o_sec  output  7  committed seconds, binary, 0..59.
REQ-011 o_valid  output  1  one-cycle pulse: o_min/o_sec just updated.
REQ-012 o_err  output  1  one-cycle pulse: entry rejected.

Function
REQ-013 Acceptance SHALL occur on a rising edge where i_digit_valid and o_ready are both high; no other cycle SHALL change the accumulation.
REQ-014 FSM states SHALL be S_D3, S_D2, S_D1, S_D0, S_COMMIT; o_digit_idx = 3,2,1,0,0 respectively.
REQ-015 o_ready SHALL be high in S_D3..S_D0 and low in S_COMMIT; digits offered in S_COMMIT SHALL be ignored, with no error.
REQ-016 An accepted digit SHALL advance S_D3->S_D2->S_D1->S_D0->S_COMMIT, storing min tens, min ones, sec tens and sec ones respectively.
REQ-017 The following SHALL each be an illegal accepted digit: greater than 9 at any position, or greater than 5 at idx 3 or idx 1.
REQ-018 An illegal digit SHALL produce the following: o_err high for exactly the next cycle; partial entry discarded; FSM to S_D3; o_min/o_sec unchanged.
REQ-019 On the edge leaving S_COMMIT, o_min SHALL load min_tens*10+min_ones and o_sec SHALL load sec_tens*10+sec_ones, with o_valid high for exactly that following cycle; FSM returns to S_D3.
REQ-020 Latency: o_valid SHALL assert one cycle after the edge that accepts the fourth digit (accept edge k, load edge k+1, pulse visible cycle k+1).
REQ-021 Between commits, o_min/o_sec SHALL hold their last committed value.
REQ-022 i_clear SHALL have the highest priority in every state, including over a simultaneous digit and over S_COMMIT: FSM to S_D3, partial entry discarded, no o_valid, no o_err, o_min/o_sec unchanged.
REQ-023 o_valid and o_err SHALL never be high in the same cycle.
REQ-024 Entry is accepted back-to-back; a new sequence may begin in the cycle o_valid is high.

Reset
REQ-025 On reset, the block SHALL set state=S_D3, o_digit_idx=3, o_ready=1, o_min=0, o_sec=0, o_valid=0, o_err=0, and all stored digits to 0.
REQ-026 Reset asserted mid-entry or in S_COMMIT SHALL discard the entry with no pulse on o_valid or o_err.

Structure
REQ-027 Shared package digit_pkg SHALL hold the state encoding, MAX_DIGIT=9, MAX_TENS=5, and digit index constants IDX_MIN_T..IDX_SEC_O.
REQ-028 One combinational sub-module, bcd2_to_bin (tens, ones -> tens*10+ones, 7-bit result), SHALL be instantiated twice; o_min takes its low 6 bits.
REQ-029 All outputs SHALL be registered; o_ready and o_digit_idx SHALL decode from the state register only.

Verification
REQ-030 Digits 4,5,3,2 on consecutive cycles -> o_min=45, o_sec=32, o_valid one cycle; feeding these values to the team's divider returns digits 4,5,3,2.
REQ-031 First digit 6 -> o_err one cycle, o_digit_idx=3, o_min/o_sec unchanged; then 5,9,5,9 -> 59:59; then 0,0,0,0 -> 0:0, two o_valid pulses.
REQ-032 Digits 1,2 then 0xA at idx 1 -> o_err, o_digit_idx=3, no o_valid.
REQ-033 Digits 1,2 then i_clear together with digit 3 -> idx 3, no pulses; then 1,2,3,4 -> 12:34.
REQ-034 i_digit_valid held high during S_COMMIT with digit 7 -> ignored; next accepted digit lands at idx 3.
REQ-035 i_reset_n pulled low between clock edges after 3 digits -> all outputs at reset values before the next edge; a full entry after release commits correctly.

Source files
------------

// File: rtl/digit_pkg.sv
// digit_pkg: state encoding, digit limits and position indices shared by the digit combiner
package digit_pkg;
  localparam logic [2:0] S_D3     = 3'd0;
  localparam logic [2:0] S_D2     = 3'd1;
  localparam logic [2:0] S_D1     = 3'd2;
  localparam logic [2:0] S_D0     = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [3:0] MAX_DIGIT = 4'd9;
  localparam logic [3:0] MAX_TENS  = 4'd5;
  localparam logic [1:0] IDX_MIN_T = 2'd3;
  localparam logic [1:0] IDX_MIN_O = 2'd2;
  localparam logic [1:0] IDX_SEC_T = 2'd1;
  localparam logic [1:0] IDX_SEC_O = 2'd0;
endpackage

// File: rtl/digit_combiner_sec_if.sv
// digit_combiner_sec_if: digit entry bus and committed mm:ss result
interface digit_combiner_sec_if;
  logic [3:0] i_digit;
  logic       i_digit_valid;
  logic       i_clear;
  logic       o_ready;
  logic [1:0] o_digit_idx;
  logic [5:0] o_min;
  logic [6:0] o_sec;
  logic       o_valid;
  logic       o_err;
  modport master (output i_digit, i_digit_valid, i_clear,
                  input  o_ready, o_digit_idx, o_min, o_sec, o_valid, o_err);
  modport slave  (input  i_digit, i_digit_valid, i_clear,
                  output o_ready, o_digit_idx, o_min, o_sec, o_valid, o_err);
endinterface

// File: rtl/bcd2_to_bin.sv
// bcd2_to_bin: two BCD digits to binary value tens*10+ones
module bcd2_to_bin (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] bin
);
  assign bin = 7'(tens) * 7'd10 + 7'(ones);
endmodule

// File: rtl/digit_combiner_sec.sv
// digit_combiner_sec: collects four BCD digits (mm:ss) and commits them as binary minutes/seconds
module digit_combiner_sec
  import digit_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  digit_combiner_sec_if.slave bus
);
  logic [2:0] state;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic [6:0] min_bin, sec_bin;
  logic       accept, illegal, unused_min_msb;
  bcd2_to_bin u_min (.tens(min_t), .ones(min_o), .bin(min_bin));
  bcd2_to_bin u_sec (.tens(sec_t), .ones(sec_o), .bin(sec_bin));
  assign unused_min_msb = min_bin[6];
  assign bus.o_ready = state != S_COMMIT;
  assign bus.o_digit_idx = state == S_D3 ? IDX_MIN_T :
                           state == S_D2 ? IDX_MIN_O :
                           state == S_D1 ? IDX_SEC_T : IDX_SEC_O;
  assign accept  = bus.i_digit_valid && bus.o_ready;
  assign illegal = bus.i_digit > MAX_DIGIT ||
                   ((bus.o_digit_idx == IDX_MIN_T || bus.o_digit_idx == IDX_SEC_T) && bus.i_digit > MAX_TENS);
  // clear beats everything; commit loads results; bad digits abort; good digits advance the position
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_D3;
      {min_t, min_o, sec_t, sec_o} <= '0;
      bus.o_min   <= '0;
      bus.o_sec   <= '0;
      bus.o_valid <= 1'b0;
      bus.o_err   <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      bus.o_err   <= 1'b0;
      if (bus.i_clear) begin
        state <= S_D3;
        {min_t, min_o, sec_t, sec_o} <= '0;
      end else if (state == S_COMMIT) begin
        bus.o_min   <= min_bin[5:0];
        bus.o_sec   <= sec_bin;
        bus.o_valid <= 1'b1;
        state       <= S_D3;
        {min_t, min_o, sec_t, sec_o} <= '0;
      end else if (accept && illegal) begin
        bus.o_err <= 1'b1;
        state     <= S_D3;
        {min_t, min_o, sec_t, sec_o} <= '0;
      end else if (accept) begin
        min_t <= state == S_D3 ? bus.i_digit : min_t;
        min_o <= state == S_D2 ? bus.i_digit : min_o;
        sec_t <= state == S_D1 ? bus.i_digit : sec_t;
        sec_o <= state == S_D0 ? bus.i_digit : sec_o;
        state <= state + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_digit_combiner_sec.sv
// tb_digit_combiner_sec: scoreboard bench for the mm:ss digit combiner
module tb_digit_combiner_sec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nchk = 0;
  int nfail = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic [12:0] exp_q[$];
  digit_combiner_sec_if bus();
  digit_combiner_sec dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic [3:0] d, input logic v, input logic clr);
    bus.i_digit = d;
    bus.i_digit_valid = v;
    bus.i_clear = clr;
    @(posedge clk);
    #1;
    bus.i_digit = 4'd0;
    bus.i_digit_valid = 1'b0;
    bus.i_clear = 1'b0;
  endtask
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    exp_q.push_back({6'(a * 10 + b), 7'(c * 10 + d)});
    step(a, 1, 0);
    step(b, 1, 0);
    step(c, 1, 0);
    step(d, 1, 0);
    step(4'd7, 1, 0);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      logic [12:0] e;
      chk("valid_and_err", 32'(bus.o_valid & bus.o_err), 0);
      if (bus.o_err) err_seen++;
      if (bus.o_valid) begin
        chk("valid_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("commit_min", 32'(bus.o_min), 32'(e[12:7]));
          chk("commit_sec", 32'(bus.o_sec), 32'(e[6:0]));
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    bus.i_digit = 4'd0;
    bus.i_digit_valid = 1'b0;
    bus.i_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.o_ready), 1);
    chk("rst_idx", 32'(bus.o_digit_idx), 3);
    chk("rst_min", 32'(bus.o_min), 0);
    chk("rst_sec", 32'(bus.o_sec), 0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_err", 32'(bus.o_err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({6'd45, 7'd32});
    step(4, 1, 0);
    step(5, 1, 0);
    step(3, 1, 0);
    step(2, 1, 0);
    chk("commit_ready", 32'(bus.o_ready), 0);
    chk("commit_idx", 32'(bus.o_digit_idx), 0);
    step(0, 0, 0);
    chk("valid_pulse", 32'(bus.o_valid), 1);
    step(0, 0, 0);
    chk("valid_one_cycle", 32'(bus.o_valid), 0);
    chk("div_min_t", 32'(bus.o_min / 10), 4);
    chk("div_min_o", 32'(bus.o_min % 10), 5);
    chk("div_sec_t", 32'(bus.o_sec / 10), 3);
    chk("div_sec_o", 32'(bus.o_sec % 10), 2);
    step(6, 1, 0);
    err_exp++;
    chk("err_first6", 32'(bus.o_err), 1);
    chk("err_idx", 32'(bus.o_digit_idx), 3);
    chk("err_min_hold", 32'(bus.o_min), 45);
    chk("err_sec_hold", 32'(bus.o_sec), 32);
    step(0, 0, 0);
    chk("err_one_cycle", 32'(bus.o_err), 0);
    send4(5, 9, 5, 9);
    send4(0, 0, 0, 0);
    step(0, 0, 0);
    chk("zero_min", 32'(bus.o_min), 0);
    step(1, 1, 0);
    step(2, 1, 0);
    step(4'hA, 1, 0);
    err_exp++;
    chk("bad_a_err", 32'(bus.o_err), 1);
    chk("bad_a_idx", 32'(bus.o_digit_idx), 3);
    step(1, 1, 0);
    step(2, 1, 0);
    step(3, 1, 1);
    chk("clr_idx", 32'(bus.o_digit_idx), 3);
    chk("clr_valid", 32'(bus.o_valid), 0);
    chk("clr_err", 32'(bus.o_err), 0);
    send4(1, 2, 3, 4);
    send4(2, 3, 4, 5);
    send4(1, 0, 2, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("clr_commit_min", 32'(bus.o_min), 10);
    chk("clr_commit_sec", 32'(bus.o_sec), 20);
    step(1, 1, 0);
    step(2, 1, 0);
    step(3, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_idx", 32'(bus.o_digit_idx), 3);
    chk("arst_ready", 32'(bus.o_ready), 1);
    chk("arst_min", 32'(bus.o_min), 0);
    chk("arst_sec", 32'(bus.o_sec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send4(3, 1, 4, 1);
    step(0, 0, 0);
    chk("final_min", 32'(bus.o_min), 31);
    chk("final_sec", 32'(bus.o_sec), 41);
    chk("err_count", 32'(err_seen), 32'(err_exp));
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
